quaternion_divider: RTL

- Recovers the left factor q1 of a Hamilton product r = q1*q2, given r and the right factor q2.
- Computes q1 = r*conj(q2) / |q2|^2 in integer arithmetic.
- Uses one shared signed multiplier and one restoring divider, run sequentially.
- Sits downstream of the 16x16 quaternion multiplier: accepts its 32-bit r1..r4 and returns signed 16-bit components.

---
 rtl/quaternion_divider.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/quaternion_divider.sv
// quaternion_divider: recovers q1 = r*conj(q2)/|q2|^2 from r = q1*q2.
// One shared signed multiplier and one restoring divider, run sequentially.
module quaternion_divider #(
  parameter int W  = 16,
  parameter int RW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [RW-1:0] r1,
  input  logic [RW-1:0] r2,
  input  logic [RW-1:0] r3,
  input  logic [RW-1:0] r4,
  input  logic [W-1:0]  a2,
  input  logic [W-1:0]  b2,
  input  logic [W-1:0]  c2,
  input  logic [W-1:0]  d2,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  a1,
  output logic [W-1:0]  b1,
  output logic [W-1:0]  c1,
  output logic [W-1:0]  d1,
  output logic          dz,
  output logic          ovf,
  output logic          inexact
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_NORM  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_MAC   = 3'd3;
  localparam logic [2:0] S_DIV   = 3'd4;
  localparam logic [2:0] S_STORE = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  // bit {k,j} set when term j of N_k is subtracted
  localparam logic [15:0] SUB_MASK = 16'h3950;
  localparam logic [5:0]  DIV_LAST = 6'd49;

  logic [2:0]           state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [1:0]           k_q, k_d;
  logic signed [RW-1:0] r_q [4];
  logic signed [RW-1:0] r_d [4];
  logic signed [W-1:0]  q_q [4];
  logic signed [W-1:0]  q_d [4];
  logic [32:0]          den_q, den_d;
  logic signed [49:0]   acc_q, acc_d;
  logic                 neg_q, neg_d;
  logic [33:0]          rem_q, rem_d;
  logic [W-1:0]         out_q [4];
  logic [W-1:0]         out_d [4];
  logic                 dz_q, dz_d;
  logic                 ovf_q, ovf_d;
  logic                 inx_q, inx_d;

  logic [1:0]           j;
  logic signed [RW-1:0] mul_x;
  logic signed [W-1:0]  mul_y;
  logic signed [47:0]   prod;
  logic                 mac_sub;
  logic signed [49:0]   term;
  logic signed [49:0]   sum;
  logic [33:0]          rem_sh;
  logic [33:0]          rem_sub;
  logic                 rem_ge;
  logic [49:0]          qmag;
  logic [W-1:0]         sat;
  logic                 sat_ovf;

  assign j = cnt_q[1:0];

  // operand select: squares of q2 in NORM, r_j * q2 term in MAC
  always_comb begin
    mul_x   = RW'(q_q[j]);
    mul_y   = q_q[j];
    mac_sub = 1'b0;
    if (state_q == S_MAC) begin
      mul_x   = r_q[j];
      mul_y   = q_q[j ^ k_q];
      mac_sub = SUB_MASK[{k_q, j}];
    end
  end

  assign prod = 48'(mul_x) * 48'(mul_y);

  // accumulate term, one restoring-division step, output clamp
  always_comb begin
    term = 50'(prod);
    if (mac_sub) term = -term;
    sum     = acc_q + term;
    rem_sh  = {rem_q[32:0], acc_q[49]};
    rem_sub = rem_sh - {1'b0, den_q};
    rem_ge  = rem_sh >= {1'b0, den_q};
    qmag    = acc_q;
    sat     = qmag[W-1:0];
    sat_ovf = 1'b0;
    if (neg_q) begin
      if (qmag > 50'd32768) begin
        sat     = 16'h8000;
        sat_ovf = 1'b1;
      end else begin
        sat = 16'd0 - qmag[15:0];
      end
    end else if (qmag > 50'd32767) begin
      sat     = 16'h7fff;
      sat_ovf = 1'b1;
    end
  end

  // sequencing: NORM, CHECK, then MAC/DIV/STORE per component
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    r_d     = r_q;
    q_d     = q_q;
    den_d   = den_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    rem_d   = rem_q;
    out_d   = out_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    inx_d   = inx_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          r_d[0]  = r1;
          r_d[1]  = r2;
          r_d[2]  = r3;
          r_d[3]  = r4;
          q_d[0]  = a2;
          q_d[1]  = b2;
          q_d[2]  = c2;
          q_d[3]  = d2;
          den_d   = '0;
          cnt_d   = '0;
          dz_d    = 1'b0;
          ovf_d   = 1'b0;
          inx_d   = 1'b0;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        den_d = den_q + {1'b0, prod[31:0]};
        cnt_d = cnt_q + 6'd1;
        if (j == 2'd3) begin
          cnt_d   = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (den_q == '0) begin
          dz_d    = 1'b1;
          out_d   = '{default: '0};
          state_d = S_DONE;
        end else begin
          k_d     = '0;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = sum;
        cnt_d = cnt_q + 6'd1;
        if (j == 2'd3) begin
          neg_d   = sum[49];
          acc_d   = sum[49] ? -sum : sum;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        rem_d = rem_ge ? rem_sub : rem_sh;
        acc_d = {acc_q[48:0], rem_ge};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        out_d[k_q] = sat;
        ovf_d      = ovf_q | sat_ovf;
        inx_d      = inx_q | (rem_q != '0);
        acc_d      = '0;
        if (k_q == 2'd3) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = S_MAC;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      den_q   <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      inx_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_q[i]   <= '0;
        q_q[i]   <= '0;
        out_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      den_q   <= den_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      inx_q   <= inx_d;
      r_q     <= r_d;
      q_q     <= q_d;
      out_q   <= out_d;
    end
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done    = (state_q == S_DONE);
  assign a1      = out_q[0];
  assign b1      = out_q[1];
  assign c1      = out_q[2];
  assign d1      = out_q[3];
  assign dz      = dz_q;
  assign ovf     = ovf_q;
  assign inexact = inx_q;

endmodule
